multibyte_add_sequencer: RTL and testbench
==========================================

MULTIBYTE_ADD_SEQUENCER -- requirements
Module: multibyte_add_sequencer

Interface
REQ-001 Parameter NBYTES, default 4: operand width in bytes; legal range 1..16.
REQ-002 CLK  in  1  the single clock; all state updates occur on the rising edge.
REQ-003 RSTn  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request to begin an addition; sampled only in IDLE.
REQ-005 opA  in  [0:8*NBYTES-1]  first operand; bit 0 is the MSB.
REQ-006 opB  in  [0:8*NBYTES-1]  second operand; bit 0 is the MSB.
REQ-007 cin  in  1  carry-in for the least significant byte.
REQ-008 busy  out  1  high while the FSM is in RUN.
REQ-009 done  out  1  one-cycle pulse; result and cout are valid.
REQ-010 result  out  [0:8*NBYTES-1]  sum; bit 0 is the MSB.
REQ-011 cout  out  1  carry out of the most significant byte.
REQ-012 AddA  out  [0:7]  byte A driven to the external 8-bit adder.
REQ-013 AddB  out  [0:7]  byte B driven to the external 8-bit adder.
REQ-014 AddCi  out  1  carry-in driven to the adder.
REQ-015 AddS  in  [0:7]  combinational sum returned from the adder.
REQ-016 AddCo  in  1  combinational carry returned from the adder.

Function
REQ-017 The FSM SHALL have three states, IDLE, RUN and DONE, encoded in registered state.
REQ-018 IDLE with start=1 SHALL latch opA, opB and cin into internal registers, clear the byte index k to 0, and enter RUN on the next edge.
REQ-019 Byte k SHALL be bits [8*(NBYTES-1-k) : 8*(NBYTES-1-k)+7] of the latched operand, so k=0 is the least significant byte.
REQ-020 In RUN, AddA and AddB SHALL combinationally present latched byte k, and AddCi SHALL present the carry register (latched cin when k=0).
REQ-021 Each RUN edge SHALL write AddS into working byte k, load AddCo into the carry register, and increment k.
REQ-022 The edge at which k=NBYTES-1 SHALL copy the working register plus the new byte into result, load AddCo into cout, and enter DONE.
REQ-023 DONE SHALL assert done for exactly one cycle and return to IDLE on the next edge.
REQ-024 Latency: done SHALL be high in the cycle after the NBYTES-th RUN edge, i.e. NBYTES+1 edges after the edge that sampled start.
REQ-025 start in RUN or DONE SHALL be ignored; operands SHALL NOT be re-latched and the in-flight operation SHALL be unaffected.
REQ-026 result and cout SHALL change only on entry to DONE and hold their values otherwise, including through subsequent IDLE and RUN.
REQ-027 When not in RUN, AddA, AddB and AddCi SHALL be 0.
REQ-028 With NBYTES=1, RUN SHALL last exactly one edge.
REQ-029 Arithmetic SHALL be unsigned modulo 2^(8*NBYTES), with the overflow reported only on cout.

Reset
REQ-030 RSTn=0 SHALL immediately force IDLE, k=0, the carry register and working register to 0, result=0, cout=0, busy=0, done=0, and AddA/AddB/AddCi=0.
REQ-031 Reset asserted in RUN or DONE SHALL abort the operation with no done pulse.
REQ-032 After RSTn rises, a start on the first edge SHALL be accepted normally.

Verification (NBYTES=4, external 8-bit adder instantiated in the bench)
REQ-033 opA=0x000000FF, opB=0x00000001, cin=0 -> result=0x00000100, cout=0, done high exactly 5 edges after the start edge, busy high for 4 cycles.
REQ-034 opA=0xFFFFFFFF, opB=0x00000000, cin=1 -> result=0x00000000, cout=1.
REQ-035 opA=0x12345678, opB=0x9ABCDEF0, cin=0 -> AddA sequence 0x78,0x56,0x34,0x12; AddCi sequence 0,1,1,0; result=0xACF13568, cout=0.
REQ-036 Start the REQ-035 addition, then pulse start with opA=opB=0 during RUN -> result is still 0xACF13568 with a single done pulse.
REQ-037 Drop RSTn during the second RUN cycle -> all outputs are 0 at once and no done pulse occurs; a start after release with opA=1, opB=2 -> result=0x00000003.

Source files
------------

// File: rtl/multibyte_add_sequencer.sv
// Multi-byte adder sequencer: adds two NBYTES-wide operands one byte per
// cycle through an external combinational 8-bit adder, LSB byte first.
//
// Ports:
//   CLK, RSTn     clock, asynchronous active-low reset
//   start         begin an addition (sampled only in IDLE)
//   opA, opB, cin operands ([0:8*NBYTES-1], bit 0 is MSB) and carry-in
//   busy          high while the sequencer is in RUN
//   done          one-cycle pulse, result/cout valid
//   result, cout  registered sum and carry out of the top byte
//   AddA, AddB, AddCi  byte operands / carry presented to the external adder
//   AddS, AddCo   combinational sum / carry returned by the external adder
module multibyte_add_sequencer #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  start,
    input  logic [0:8*NBYTES-1]   opA,
    input  logic [0:8*NBYTES-1]   opB,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [0:8*NBYTES-1]   result,
    output logic                  cout,
    output logic [0:7]            AddA,
    output logic [0:7]            AddB,
    output logic                  AddCi,
    input  logic [0:7]            AddS,
    input  logic                  AddCo
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [0:W-1]    opa_q, opa_d;
    logic [0:W-1]    opb_q, opb_d;
    logic [0:W-1]    work_q, work_d;
    logic            carry_q, carry_d;
    logic [0:W-1]    result_q, result_d;
    logic            cout_q, cout_d;

    // State and datapath registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            work_q   <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            work_q   <= work_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    // Next-state, byte steering and external adder drive
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        work_d   = work_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        AddA     = '0;
        AddB     = '0;
        AddCi    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d   = opA;
                    opb_d   = opB;
                    carry_d = cin;
                    work_d  = '0;
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                AddCi = carry_q;
                // Byte k sits at the high-index end of the MSB-first vector
                for (int i = 0; i < int'(NBYTES); i++) begin
                    if (KW'(i) == k_q) begin
                        AddA = opa_q[8*(int'(NBYTES)-1-i) +: 8];
                        AddB = opb_q[8*(int'(NBYTES)-1-i) +: 8];
                        work_d[8*(int'(NBYTES)-1-i) +: 8] = AddS;
                    end
                end
                carry_d = AddCo;
                k_d     = k_q + KW'(1);
                if (k_q == KW'(NBYTES - 1)) begin
                    // work_d already holds the final byte
                    result_d = work_d;
                    cout_d   = AddCo;
                    k_d      = '0;
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Self-checking bench for multibyte_add_sequencer (NBYTES=4) with a
// behavioural 8-bit adder and a whole-word arithmetic reference model.
module tb_multibyte_add_sequencer;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    logic           CLK;
    logic           RSTn;
    logic           start;
    logic [0:W-1]   opA;
    logic [0:W-1]   opB;
    logic           cin;
    logic           busy;
    logic           done;
    logic [0:W-1]   result;
    logic           cout;
    logic [0:7]     AddA;
    logic [0:7]     AddB;
    logic           AddCi;
    logic [0:7]     AddS;
    logic           AddCo;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the registered outputs
    logic [W-1:0] model_res  = '0;
    logic         model_cout = 1'b0;

    multibyte_add_sequencer #(.NBYTES(NB)) dut (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .start  (start),
        .opA    (opA),
        .opB    (opB),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .AddA   (AddA),
        .AddB   (AddB),
        .AddCi  (AddCi),
        .AddS   (AddS),
        .AddCo  (AddCo)
    );

    // External combinational 8-bit adder
    assign {AddCo, AddS} = {1'b0, AddA} + {1'b0, AddB} + {8'd0, AddCi};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One addition; poke=1 pulses start with zero operands mid-RUN
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit poke);
        longint unsigned la, lb, lc, m, s, full;
        int  neg_n;
        int  busy_n;
        bit  seen;
        la = 64'(a); lb = 64'(b); lc = 64'(c);
        full = la + lb + lc;
        opA = a; opB = b; cin = c; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        seen = 0; neg_n = 0; busy_n = 0;
        while (!seen && neg_n < 40) begin
            @(negedge CLK);
            neg_n++;
            if (poke && neg_n == 2) begin
                opA = '0; opB = '0; start = 1'b1;
            end else if (poke && neg_n == 3) begin
                start = 1'b0;
            end
            if (busy) begin
                // Carry into byte k = carry out of the low k bytes
                m = (64'd1 << (8 * busy_n)) - 64'd1;
                s = (la & m) + (lb & m) + lc;
                check_eq("add_a", 64'(AddA), (la >> (8 * busy_n)) & 64'hFF);
                check_eq("add_b", 64'(AddB), (lb >> (8 * busy_n)) & 64'hFF);
                check_eq("add_ci", 64'(AddCi), (s >> (8 * busy_n)) & 64'd1);
                busy_n++;
            end else begin
                check_eq("add_idle", {AddA, AddB, AddCi}, 64'd0);
            end
            if (done) seen = 1;
            else begin
                check_eq("result_hold", 64'(result), 64'(model_res));
                check_eq("cout_hold", 64'(cout), 64'(model_cout));
            end
        end
        check_eq("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            model_res  = W'(full);
            model_cout = 1'(full >> W);
            check_eq("done_latency", 64'(neg_n), 64'(NB + 1));
            check_eq("busy_cycles", 64'(busy_n), 64'(NB));
            check_eq("result", 64'(result), 64'(model_res));
            check_eq("cout", 64'(cout), 64'(model_cout));
            @(negedge CLK);
            check_eq("done_pulse", 64'(done), 64'd0);
            check_eq("idle_busy", 64'(busy), 64'd0);
            if (poke) begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge CLK);
                    check_eq("no_extra_op", {busy, done}, 64'd0);
                end
            end
            check_eq("result_kept", 64'(result), 64'(model_res));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {busy, done, cout, AddCi, AddA, AddB}, 64'd0);
        check_eq({tag, "_res"}, 64'(result), 64'd0);
    endtask

    initial begin
        RSTn = 1'b0; start = 1'b0; opA = '0; opB = '0; cin = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge CLK);
        check_all_zero("reset_held");
        RSTn = 1'b1;

        // Start on the first edge after release
        run_op(32'h000000FF, 32'h00000001, 1'b0, 0);
        check_eq("r033", 64'(result), 64'h00000100);
        run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 0);
        check_eq("r034", 64'(result), 64'h00000000);
        check_eq("r034_cout", 64'(cout), 64'd1);
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 0);
        check_eq("r035", 64'(result), 64'hACF13568);
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 1);
        check_eq("r036", 64'(result), 64'hACF13568);

        // Reset during the second RUN cycle aborts the operation
        opA = 32'h12345678; opB = 32'h9ABCDEF0; cin = 1'b0; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check_eq("pre_abort_busy", 64'(busy), 64'd1);
        RSTn = 1'b0;
        #1;
        check_all_zero("abort");
        model_res = '0; model_cout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check_eq("abort_no_done", {busy, done}, 64'd0);
        end
        RSTn = 1'b1;
        run_op(32'h00000001, 32'h00000002, 1'b0, 0);
        check_eq("r037", 64'(result), 64'h00000003);

        // Randomised operands including carry-chain extremes
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            if (i % 5 == 0) a = '1;
            if (i % 7 == 0) b = ~a;
            run_op(a, b, 1'($urandom_range(0, 1)), (i % 4) == 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
